// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter sequencer and single-outstanding instruction fetch FSM
//
// Purpose:
//   Holds the program counter, issues one instruction-memory read at a time,
//   registers the returned instruction, and computes the next PC from
//   jump / branch / sequential sources once the instruction executes.
//   A misaligned fetch target halts the unit until reset.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   branch_next   in   1   branch taken for the instruction in EXEC
//   branch_target in  32   branch destination
//   jump          in   1   unconditional jump for the instruction in EXEC
//   jump_target   in  32   jump destination, bit 0 dropped
//   stall         in   1   downstream hold while in EXEC
//   imem_req      out  1   instruction read request (FETCH only)
//   imem_addr     out 32   instruction read address (= pc)
//   imem_ack      in   1   read data valid this cycle
//   imem_rdata    in  32   instruction word
//   instr         out 32   registered instruction
//   instr_pc      out 32   address of instr
//   instr_valid   out  1   instr / instr_pc valid (EXEC only)
//   misaligned    out  1   sticky misaligned-target trap

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_next,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;

  // Redirect selection; jump outranks branch. Only consumed in EXEC with
  // stall low, so the inputs may be garbage in every other cycle.
  always_comb begin
    next_pc = instr_pc_q + 32'd4;
    if (jump) begin
      next_pc = jump_target & 32'hFFFF_FFFE;
    end else if (branch_next) begin
      next_pc = branch_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      mis_q      <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    mis_d      = mis_q;
    case (state_q)
      S_BOOT: begin
        // imem_ack is deliberately not looked at here: a response to a
        // request abandoned by reset must not be captured.
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (next_pc[1:0] != 2'b00) begin
            // pc keeps the faulting instruction's address for debug.
            mis_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Outputs are pure decodes of registered state so reset reaches them
  // without waiting for a clock.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == S_EXEC);
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit

module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branch_next;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misaligned;

  int checks;
  int errors;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_next  (branch_next),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns address + 0x1000_0000 so every word is distinct.
  assign imem_rdata = imem_addr + 32'h1000_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000000", imem_addr); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h exp 00000000", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_misaligned got %b exp 0", misaligned); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    release_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(4 * i);
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL seq_fetch%0d got req %b addr %h exp req 1 addr %h", i, imem_req, imem_addr, exp_pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_fetch_valid%0d got %b exp 0", i, instr_valid); end
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin errors++; $display("FAIL seq_exec%0d got valid %b pc %h exp valid 1 pc %h", i, instr_valid, instr_pc, exp_pc); end
      checks++; if (instr !== exp_pc + 32'h1000_0000 || imem_req !== 1'b0) begin errors++; $display("FAIL seq_instr%0d got %h req %b exp %h req 0", i, instr, imem_req, exp_pc + 32'h1000_0000); end
    end
  endtask

  task automatic test_branch();
    // EXEC at 0x8: taken branch to 0x10 to reach the scenario address.
    branch_next = 1'b1; branch_target = 32'h10;
    step();
    branch_next = 1'b0;
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_to10 got %h exp 00000010", imem_addr); end
    step();
    checks++; if (instr_pc !== 32'h10 || instr_valid !== 1'b1) begin errors++; $display("FAIL br_exec10 got pc %h valid %b exp pc 00000010 valid 1", instr_pc, instr_valid); end
    branch_next = 1'b1; branch_target = 32'h40;
    step();
    branch_next = 1'b0;
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL br_taken got addr %h req %b exp 00000040 req 1", imem_addr, imem_req); end
    step();
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL br_exec40 got %h exp 00000040", instr_pc); end
    branch_next = 1'b1; branch_target = 32'h10;
    step();
    branch_next = 1'b0; branch_target = 32'h80;
    step();
    checks++; if (instr_pc !== 32'h10) begin errors++; $display("FAIL br_back10 got %h exp 00000010", instr_pc); end
    step();
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL br_not_taken got %h exp 00000014", imem_addr); end
    step();
    checks++; if (instr_pc !== 32'h14) begin errors++; $display("FAIL br_exec14 got %h exp 00000014", instr_pc); end
  endtask

  task automatic test_priority();
    jump = 1'b1; jump_target = 32'h101;
    branch_next = 1'b1; branch_target = 32'h80;
    step();
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL prio_jalr got %h exp 00000100", imem_addr); end
    // Redirect inputs asserted during FETCH must have no effect.
    jump_target = 32'h200; imem_ack = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("FAIL prio_fetch_ignore got addr %h req %b exp 00000100 req 1", imem_addr, imem_req); end
    jump = 1'b0; branch_next = 1'b0; imem_ack = 1'b1;
    step();
    checks++; if (instr_pc !== 32'h100 || instr !== 32'h1000_0100) begin errors++; $display("FAIL prio_exec got pc %h instr %h exp 00000100 10000100", instr_pc, instr); end
  endtask

  task automatic test_stall_wait();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h1000_0100) begin errors++; $display("FAIL stall%0d got valid %b pc %h instr %h exp 1 00000100 10000100", i, instr_valid, instr_pc, instr); end
      checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_pc%0d got addr %h req %b exp 00000100 req 0", i, imem_addr, imem_req); end
    end
    stall = 1'b0; imem_ack = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h104 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_fetch got addr %h req %b exp 00000104 req 1", imem_addr, imem_req); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_addr !== 32'h104 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait_hold%0d got addr %h req %b valid %b exp 00000104 1 0", i, imem_addr, imem_req, instr_valid); end
    end
    imem_ack = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h104 || instr !== 32'h1000_0104) begin errors++; $display("FAIL wait_exec got valid %b pc %h instr %h exp 1 00000104 10000104", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_misalign();
    branch_next = 1'b1; branch_target = 32'h22;
    step();
    branch_next = 1'b0;
    checks++; if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mis_trap got mis %b req %b valid %b exp 1 0 0", misaligned, imem_req, instr_valid); end
    checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL mis_pc_hold got %h exp 00000104", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (misaligned !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mis_halt%0d got mis %b req %b valid %b exp 1 0 0", i, misaligned, imem_req, instr_valid); end
    end
    rst = 1'b1;
    #1;
    checks++; if (misaligned !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL mis_rst got mis %b addr %h exp 0 00000000", misaligned, imem_addr); end
    release_reset();
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mis_restart got req %b addr %h exp 1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    step();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump got %h exp fffffffc", imem_addr); end
    step();
    checks++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_exec got pc %h instr %h exp fffffffc 0ffffffc", instr_pc, instr); end
    step();
    checks++; if (imem_addr !== 32'h0 || misaligned !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_seq got addr %h mis %b req %b exp 00000000 0 1", imem_addr, misaligned, imem_req); end
  endtask

  task automatic test_async_reset();
    step();
    step();
    step();
    step();
    imem_ack = 1'b0;
    checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin errors++; $display("FAIL arst_pre got addr %h req %b exp 00000008 1", imem_addr, imem_req); end
    #3 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL arst_now got req %b addr %h valid %b exp 0 00000000 0", imem_req, imem_addr, instr_valid); end
    checks++; if (instr !== 32'h0000_0013 || instr_pc !== 32'h0 || misaligned !== 1'b0) begin errors++; $display("FAIL arst_regs got instr %h pc %h mis %b exp 00000013 00000000 0", instr, instr_pc, misaligned); end
    imem_ack = 1'b1;
    release_reset();
    step();
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || instr !== 32'h0000_0013) begin errors++; $display("FAIL arst_stray_ack got valid %b req %b instr %h exp 0 1 00000013", instr_valid, imem_req, instr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL arst_first got valid %b pc %h exp 1 00000000", instr_valid, instr_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    branch_next = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_target = 32'h0;
    stall = 1'b0;
    imem_ack = 1'b1;
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_stall_wait();
    test_misalign();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
